mmio_master: RTL and testbench

MMIO_MASTER -- requirements
Module: mmio_master

---
 rtl/mmio_master_pkg.sv | 31 +++
 rtl/mmio_master_if.sv | 60 ++++++
 rtl/mmio_master.sv | 195 +++++++++++++++++++
 tb/tb_mmio_master.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_master_pkg.sv
// mmio_master_pkg
// Shared AXI-Lite definitions for the MMIO master:
//   - AXI response codes (OKAY / EXOKAY / SLVERR / DECERR)
//   - fixed protection attribute driven on AxPROT
//   - the master FSM state encoding
//   - resp_is_err(): classifies a response code as an error completion
package mmio_master_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Unprivileged, secure, data access.
    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW_W = 3'd3,
        ST_B    = 3'd4,
        ST_RESP = 3'd5
    } state_e;

    // Only SLVERR and DECERR are errors; the MSB distinguishes them from OKAY/EXOKAY.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
    endfunction

endpackage

// File: rtl/mmio_master_if.sv
// mmio_master_if
// AXI-Lite bus between the MMIO master and a slave.
//   AR: axi_araddr, axi_arvalid, axi_arprot (master->slave), axi_arready (slave->master)
//   R : axi_rdata, axi_rresp, axi_rvalid (slave->master), axi_rready (master->slave)
//   AW: axi_awaddr, axi_awvalid, axi_awprot (master->slave), axi_awready (slave->master)
//   W : axi_wdata, axi_wstrb, axi_wvalid (master->slave), axi_wready (slave->master)
//   B : axi_bresp, axi_bvalid (slave->master), axi_bready (master->slave)
interface mmio_master_if;

    logic [31:0] axi_araddr;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [2:0]  axi_arprot;

    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rvalid;
    logic        axi_rready;

    logic [31:0] axi_awaddr;
    logic        axi_awvalid;
    logic        axi_awready;
    logic [2:0]  axi_awprot;

    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wvalid;
    logic        axi_wready;

    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready;

    modport master (
        output axi_araddr, axi_arvalid, axi_arprot,
        input  axi_arready,
        input  axi_rdata, axi_rresp, axi_rvalid,
        output axi_rready,
        output axi_awaddr, axi_awvalid, axi_awprot,
        input  axi_awready,
        output axi_wdata, axi_wstrb, axi_wvalid,
        input  axi_wready,
        input  axi_bresp, axi_bvalid,
        output axi_bready
    );

    modport slave (
        input  axi_araddr, axi_arvalid, axi_arprot,
        output axi_arready,
        output axi_rdata, axi_rresp, axi_rvalid,
        input  axi_rready,
        input  axi_awaddr, axi_awvalid, axi_awprot,
        output axi_awready,
        input  axi_wdata, axi_wstrb, axi_wvalid,
        output axi_wready,
        output axi_bresp, axi_bvalid,
        input  axi_bready
    );

endinterface

// File: rtl/mmio_master.sv
// mmio_master
// Turns single core MMIO requests into AXI-Lite read or write transactions,
// one outstanding at a time, and returns a one-cycle completion pulse.
// Ports:
//   clk, rstn          clock (rising edge) and synchronous active-low reset
//   req_valid_i        core request present
//   req_ready_o        high exactly while idle (the only unregistered output)
//   req_write_i        1 = write, 0 = read
//   req_addr_i         byte address
//   req_wdata_i        write data
//   req_wstrb_i        write byte enables
//   resp_valid_o       one-cycle completion pulse, no backpressure
//   resp_rdata_o       read data; 0 for writes and errors
//   resp_err_o         completion carried an error
//   axi                AXI-Lite master port
// ALIGN_CHECK = 1 completes word-misaligned requests locally with an error,
// never touching the bus.
module mmio_master
    import mmio_master_pkg::*;
#(
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic               req_write_i,
    input  logic [31:0]        req_addr_i,
    input  logic [31:0]        req_wdata_i,
    input  logic [3:0]         req_wstrb_i,
    output logic               resp_valid_o,
    output logic [31:0]        resp_rdata_o,
    output logic               resp_err_o,
    mmio_master_if.master      axi
);

    state_e      state_q, state_d;

    logic [31:0] araddr_q, araddr_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic [31:0] wdata_q,  wdata_d;
    logic [3:0]  wstrb_q,  wstrb_d;

    logic        arvalid_q, arvalid_d;
    logic        rready_q,  rready_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q,  wvalid_d;
    logic        bready_q,  bready_d;

    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q,   resp_err_d;

    logic        aw_done;
    logic        w_done;
    logic        misaligned;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            araddr_q     <= '0;
            awaddr_q     <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            araddr_q     <= araddr_d;
            awaddr_q     <= awaddr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        araddr_d     = araddr_q;
        awaddr_d     = awaddr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        bready_d     = bready_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;

        misaligned = ALIGN_CHECK && (req_addr_i[1:0] != 2'b00);
        // A channel is finished once its valid has dropped or it handshakes this cycle.
        aw_done    = !awvalid_q || axi.axi_awready;
        w_done     = !wvalid_q  || axi.axi_wready;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    // Bus address/data only ever change here, on acceptance.
                    araddr_d = req_addr_i;
                    awaddr_d = req_addr_i;
                    wdata_d  = req_wdata_i;
                    wstrb_d  = req_wstrb_i;
                    if (misaligned) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end else if (req_write_i) begin
                        state_d   = ST_AW_W;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = ST_AR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            ST_AR: begin
                if (axi.axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_R;
                end
            end
            ST_R: begin
                if (axi.axi_rvalid) begin
                    rready_d     = 1'b0;
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = resp_is_err(axi.axi_rresp);
                    resp_rdata_d = resp_is_err(axi.axi_rresp) ? 32'h0 : axi.axi_rdata;
                end
            end
            ST_AW_W: begin
                // AW and W retire independently, in either order or together.
                if (awvalid_q && axi.axi_awready) awvalid_d = 1'b0;
                if (wvalid_q  && axi.axi_wready)  wvalid_d  = 1'b0;
                if (aw_done && w_done) begin
                    state_d  = ST_B;
                    bready_d = 1'b1;
                end
            end
            ST_B: begin
                if (axi.axi_bvalid) begin
                    bready_d     = 1'b0;
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = resp_is_err(axi.axi_bresp);
                    resp_rdata_d = '0;
                end
            end
            ST_RESP: begin
                state_d      = ST_IDLE;
                resp_rdata_d = '0;
                resp_err_d   = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign req_ready_o      = (state_q == ST_IDLE);
    assign resp_valid_o     = resp_valid_q;
    assign resp_rdata_o     = resp_rdata_q;
    assign resp_err_o       = resp_err_q;

    assign axi.axi_araddr  = araddr_q;
    assign axi.axi_arvalid = arvalid_q;
    assign axi.axi_arprot  = AXI_PROT_DEFAULT;
    assign axi.axi_rready  = rready_q;
    assign axi.axi_awaddr  = awaddr_q;
    assign axi.axi_awvalid = awvalid_q;
    assign axi.axi_awprot  = AXI_PROT_DEFAULT;
    assign axi.axi_wdata   = wdata_q;
    assign axi.axi_wstrb   = wstrb_q;
    assign axi.axi_wvalid  = wvalid_q;
    assign axi.axi_bready  = bready_q;

endmodule

// File: tb/tb_mmio_master.sv
// tb_mmio_master
// Self-checking bench for mmio_master: a reactive AXI-Lite slave driven from
// tasks, a scoreboard queue of expected completions (data, error, cycle) and
// a monitor that pops and compares every resp_valid pulse.
module tb_mmio_master;
    import mmio_master_pkg::*;

    logic        clk;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    mmio_master_if bus();

    mmio_master #(.ALIGN_CHECK(1'b1)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_write_i  (req_write),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .req_wstrb_i  (req_wstrb),
        .resp_valid_o (resp_valid),
        .resp_rdata_o (resp_rdata),
        .resp_err_o   (resp_err),
        .axi          (bus)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    bit   any_axi_valid = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Completion monitor and bus activity tracker, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.axi_arvalid || bus.axi_awvalid || bus.axi_wvalid) any_axi_valid = 1'b1;
        if (resp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_resp", 64'(resp_valid), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("resp_rdata", 64'(resp_rdata), 64'(e.rdata));
                check_eq("resp_err",   64'(resp_err),   64'(e.err));
                check_eq("resp_cycle", 64'(cyc),        64'(e.cyc));
            end
        end
    end

    task automatic slave_ar(input int lat, input logic [31:0] addr);
        int k = 0;
        bit done = 1'b0;
        while (!done && k < 60) begin
            check_eq("rready_early", 64'(bus.axi_rready), 64'd0);
            if (bus.axi_arvalid && k >= lat) begin
                check_eq("araddr", 64'(bus.axi_araddr), 64'(addr));
                check_eq("arprot", 64'(bus.axi_arprot), 64'd0);
                bus.axi_arready = 1'b1;
                done = 1'b1;
            end else begin
                bus.axi_arready = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        bus.axi_arready = 1'b0;
        if (!done) check_eq("ar_timeout", 64'd0, 64'd1);
        else       check_eq("arvalid_drop", 64'(bus.axi_arvalid), 64'd0);
    endtask

    task automatic slave_r(input int lat, input logic [31:0] data, input logic [1:0] resp);
        int k = 0;
        bit done = 1'b0;
        while (!done && k < 60) begin
            if (bus.axi_rready && k >= lat) begin
                bus.axi_rvalid = 1'b1;
                bus.axi_rdata  = data;
                bus.axi_rresp  = resp;
                done = 1'b1;
            end else begin
                bus.axi_rvalid = 1'b0;
                bus.axi_rdata  = 32'hBAD0_BAD0;
                bus.axi_rresp  = AXI_RESP_SLVERR;
            end
            @(negedge clk);
            k++;
        end
        bus.axi_rvalid = 1'b0;
        if (!done) check_eq("r_timeout", 64'd0, 64'd1);
        else       check_eq("rready_drop", 64'(bus.axi_rready), 64'd0);
    endtask

    task automatic slave_aw(input int lat, input logic [31:0] addr);
        int k = 0;
        bit done = 1'b0;
        while (!done && k < 60) begin
            check_eq("bready_early_aw", 64'(bus.axi_bready), 64'd0);
            if (bus.axi_awvalid && k >= lat) begin
                check_eq("awaddr", 64'(bus.axi_awaddr), 64'(addr));
                check_eq("awprot", 64'(bus.axi_awprot), 64'd0);
                bus.axi_awready = 1'b1;
                done = 1'b1;
            end else begin
                bus.axi_awready = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        bus.axi_awready = 1'b0;
        if (!done) check_eq("aw_timeout", 64'd0, 64'd1);
        else       check_eq("awvalid_drop", 64'(bus.axi_awvalid), 64'd0);
    endtask

    task automatic slave_w(input int lat, input logic [31:0] data, input logic [3:0] strb);
        int k = 0;
        bit done = 1'b0;
        while (!done && k < 60) begin
            check_eq("bready_early_w", 64'(bus.axi_bready), 64'd0);
            if (bus.axi_wvalid && k >= lat) begin
                check_eq("wdata", 64'(bus.axi_wdata), 64'(data));
                check_eq("wstrb", 64'(bus.axi_wstrb), 64'(strb));
                bus.axi_wready = 1'b1;
                done = 1'b1;
            end else begin
                bus.axi_wready = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        bus.axi_wready = 1'b0;
        if (!done) check_eq("w_timeout", 64'd0, 64'd1);
        else       check_eq("wvalid_drop", 64'(bus.axi_wvalid), 64'd0);
    endtask

    task automatic slave_b(input int lat, input logic [1:0] resp);
        int k = 0;
        bit done = 1'b0;
        while (!done && k < 60) begin
            if (bus.axi_bready && k >= lat) begin
                bus.axi_bvalid = 1'b1;
                bus.axi_bresp  = resp;
                done = 1'b1;
            end else begin
                bus.axi_bvalid = 1'b0;
                bus.axi_bresp  = AXI_RESP_DECERR;
            end
            @(negedge clk);
            k++;
        end
        bus.axi_bvalid = 1'b0;
        if (!done) check_eq("b_timeout", 64'd0, 64'd1);
        else       check_eq("bready_drop", 64'(bus.axi_bready), 64'd0);
    endtask

    // Presents one request at the current negedge; returns its acceptance cycle.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] strb, output int n);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        req_wstrb = strb;
        check_eq("req_ready_idle", 64'(req_ready), 64'd1);
        n = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'h5555_5555;
        check_eq("req_ready_busy", 64'(req_ready), 64'd0);
    endtask

    task automatic do_read(input logic [31:0] addr, input int ar_lat, input int r_lat,
                           input logic [31:0] data, input logic [1:0] resp);
        int   n;
        exp_t e;
        bit   mis = (addr[1:0] != 2'b00);
        if (mis) begin
            // Misaligned requests complete one cycle after acceptance, nothing on the bus.
            e.rdata = 32'h0;
            e.err   = 1'b1;
            issue(1'b0, addr, 32'h0, 4'h0, n);
            e.cyc = n + 1;
            sb.push_back(e);
        end else begin
            e.err   = (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
            e.rdata = e.err ? 32'h0 : data;
            issue(1'b0, addr, 32'h0, 4'h0, n);
            e.cyc = n + 3 + ar_lat + r_lat;
            sb.push_back(e);
            slave_ar(ar_lat, addr);
            slave_r(r_lat, data, resp);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] strb,
                            input int aw_lat, input int w_lat, input int b_lat, input logic [1:0] resp);
        int   n;
        exp_t e;
        e.rdata = 32'h0;
        e.err   = (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
        issue(1'b1, addr, wd, strb, n);
        e.cyc = n + 3 + ((aw_lat > w_lat) ? aw_lat : w_lat) + b_lat;
        sb.push_back(e);
        fork
            slave_aw(aw_lat, addr);
            slave_w(w_lat, wd, strb);
        join
        slave_b(b_lat, resp);
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while (sb.size() != 0 && k < 30) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        check_eq(tag, 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rstn      = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        bus.axi_arready = 1'b0;
        bus.axi_rvalid  = 1'b0;
        bus.axi_rdata   = '0;
        bus.axi_rresp   = '0;
        bus.axi_awready = 1'b0;
        bus.axi_wready  = 1'b0;
        bus.axi_bvalid  = 1'b0;
        bus.axi_bresp   = '0;

        repeat (3) @(negedge clk);
        check_eq("rst_req_ready", 64'(req_ready), 64'd1);
        check_eq("rst_valids", 64'({bus.axi_arvalid, bus.axi_rready, bus.axi_awvalid,
                                    bus.axi_wvalid, bus.axi_bready, resp_valid, resp_err}), 64'd0);
        check_eq("rst_rdata", 64'(resp_rdata), 64'd0);
        check_eq("rst_addr",  64'({bus.axi_araddr, bus.axi_awaddr}), 64'd0);
        check_eq("rst_wdata", 64'({bus.axi_wdata, bus.axi_wstrb}), 64'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Minimum-latency read of the uart priority register.
        do_read(32'h0000_0028, 0, 0, 32'h0000_0003, AXI_RESP_OKAY);
        drain("drain_read_min");

        // Write with W accepted three cycles before AW.
        do_write(32'h0020_1004, 32'h0000_000A, 4'hF, 3, 0, 0, AXI_RESP_OKAY);
        drain("drain_write_wfirst");

        // AW first, then W; and a minimum-latency write.
        do_write(32'h0000_0100, 32'h1234_5678, 4'h3, 0, 2, 1, AXI_RESP_OKAY);
        drain("drain_write_awfirst");
        do_write(32'h0000_0200, 32'hCAFE_F00D, 4'hC, 0, 0, 0, AXI_RESP_OKAY);
        drain("drain_write_min");

        // Error completions zero the read data.
        do_read(32'h0000_0040, 1, 2, 32'hDEAD_BEEF, AXI_RESP_SLVERR);
        drain("drain_read_slverr");
        do_read(32'h0000_0044, 0, 0, 32'h1111_2222, AXI_RESP_DECERR);
        drain("drain_read_decerr");
        do_write(32'h0000_0048, 32'h0, 4'h1, 1, 1, 2, AXI_RESP_SLVERR);
        drain("drain_write_slverr");

        // Misaligned read and write never reach the bus.
        any_axi_valid = 1'b0;
        do_read(32'h0000_0006, 0, 0, 32'h0, AXI_RESP_OKAY);
        drain("drain_misaligned_rd");
        begin
            exp_t e;
            e.rdata = 32'h0;
            e.err   = 1'b1;
            issue(1'b1, 32'h0000_0201, 32'hFFFF_FFFF, 4'hF, n);
            e.cyc = n + 1;
            sb.push_back(e);
        end
        drain("drain_misaligned_wr");
        check_eq("misaligned_no_axi_valid", 64'(any_axi_valid), 64'd0);

        // Reset while waiting in B abandons the write.
        issue(1'b1, 32'h0000_0300, 32'h0BAD_0BAD, 4'hF, n);
        fork
            slave_aw(0, 32'h0000_0300);
            slave_w(0, 32'h0BAD_0BAD, 4'hF);
        join
        check_eq("in_b_bready", 64'(bus.axi_bready), 64'd1);
        rstn = 1'b0;
        @(negedge clk);
        check_eq("midrst_valids", 64'({bus.axi_arvalid, bus.axi_rready, bus.axi_awvalid,
                                       bus.axi_wvalid, bus.axi_bready, resp_valid}), 64'd0);
        check_eq("midrst_req_ready", 64'(req_ready), 64'd1);
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        do_read(32'h0000_0004, 0, 0, 32'hA5A5_0004, AXI_RESP_OKAY);
        drain("drain_after_reset");

        // Randomised mix of reads and writes with random slave latencies.
        for (int i = 0; i < 24; i++) begin
            logic [31:0] a;
            logic [31:0] d;
            logic [1:0]  r;
            a = {$urandom_range(0, 32'hFFFF), 16'h0} | 32'($urandom_range(0, 255) << 2);
            d = $urandom;
            r = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                do_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 3), r);
            else
                do_read(a, $urandom_range(0, 3), $urandom_range(0, 3), d, r);
            drain("drain_random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
